// File: rtl/mux32_rr_sched_if.sv
// Request/grant bundle between the requesting lanes and the 32:1 mux scheduler.
// The scheduler takes the slave modport. The lane side, or a bench, takes the master modport.
interface mux32_rr_sched_if #(
    parameter int N      = 32,
    parameter int SELW   = 5,
    parameter int HOLD_W = 4
);
    logic              en;
    logic [N-1:0]      req;
    logic [N-1:0]      data;
    logic [HOLD_W-1:0] hold_len;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      gnt;
    logic              y;
    logic              y_valid;
    logic              busy;

    modport master (
        output en, req, data, hold_len,
        input  sel, gnt, y, y_valid, busy
    );

    modport slave (
        input  en, req, data, hold_len,
        output sel, gnt, y, y_valid, busy
    );
endinterface

// File: rtl/mux32_rr_sched.sv
// Round-robin scheduler that owns the select of a shared 32:1 bit mux.
// Each grant is held for hold_len cycles, or ends early when the grantee drops its request.
module mux32_rr_sched #(
    parameter int N      = 32,
    parameter int SELW   = 5,
    parameter int HOLD_W = 4
) (
    input logic           clk,
    input logic           rst,
    mux32_rr_sched_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state;
    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   sel_q;
    logic [N-1:0]      gnt_q;
    logic [HOLD_W-1:0] cnt;

    logic [SELW-1:0]   win;
    logic [SELW-1:0]   idx;
    logic              found;
    logic              done;
    logic              load;

    // Find the first requester at or above ptr. The 5-bit add gives the 31->0 wrap.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + SELW'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        done = (cnt == HOLD_W'(1)) || !bus.req[sel_q];
        load = bus.en && found && ((state == IDLE) || done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            gnt_q <= '0;
            cnt   <= '0;
        end else begin
            if (state == GRANT)
                cnt <= cnt - HOLD_W'(1);
            if (load) begin
                // A back-to-back grant loads here with no idle cycle in between.
                state <= GRANT;
                sel_q <= win;
                gnt_q <= N'(1) << win;
                ptr   <= win + SELW'(1);
                cnt   <= (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
            end else if (state == GRANT && done) begin
                state <= IDLE;
                gnt_q <= '0;
            end
        end
    end

    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state == GRANT);
    assign bus.y       = bus.data[sel_q];
    assign bus.y_valid = (state == GRANT) && bus.req[sel_q];
endmodule

// File: tb/tb_mux32_rr_sched.sv
// Directed and random stimulus for mux32_rr_sched, checked against a cycle-level reference model.
module tb_mux32_rr_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state, kept as plain ints.
    int   m_active = 0;
    int   m_sel    = 0;
    int   m_rem    = 0;
    int   m_ptr    = 0;

    mux32_rr_sched_if bus ();
    mux32_rr_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [31:0] rq, input logic [3:0] h);
        int  w;
        bit  ended;
        if (r) begin
            m_active = 0; m_sel = 0; m_ptr = 0; m_rem = 0;
        end else begin
            ended = 0;
            if (m_active != 0) begin
                m_rem--;
                ended = (m_rem == 0) || !rq[m_sel];
            end
            if (m_active == 0 || ended) begin
                if (e && rq != 0) begin
                    w = -1;
                    for (int k = 0; k < 32; k++)
                        if (w < 0 && rq[(m_ptr + k) % 32]) w = (m_ptr + k) % 32;
                    m_sel    = w;
                    m_rem    = (h == 0) ? 1 : int'(h);
                    m_ptr    = (w + 1) % 32;
                    m_active = 1;
                end else begin
                    m_active = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eg;
        eg = (m_active != 0) ? (32'd1 << m_sel) : 32'd0;
        chk({tag, ".sel"}, 32'(bus.sel), 32'(m_sel));
        chk({tag, ".gnt"}, bus.gnt, eg);
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_active != 0));
        chk({tag, ".y"}, 32'(bus.y), 32'(bus.data[m_sel]));
        chk({tag, ".y_valid"}, 32'(bus.y_valid), 32'((m_active != 0) && bus.req[m_sel]));
    endtask

    // Drive one cycle of inputs, check the combinational outputs before the edge, then check everything after it.
    task automatic step(input string tag, input logic r, input logic e, input logic [31:0] rq,
                        input logic [31:0] dt, input logic [3:0] h);
        rst = r; bus.en = e; bus.req = rq; bus.data = dt; bus.hold_len = h;
        #1;
        chk({tag, ".pre_y"}, 32'(bus.y), 32'(dt[m_sel]));
        chk({tag, ".pre_yv"}, 32'(bus.y_valid), 32'((m_active != 0) && rq[m_sel]));
        model_edge(r, e, rq, h);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int seq [5];
        logic [31:0] rq;
        seq = '{0, 4, 31, 0, 4};
        rst = 1'b1; bus.en = 1'b0; bus.req = '0; bus.data = '0; bus.hold_len = '0;

        // Reset with every lane requesting, then lane 0 wins first.
        step("rst0", 1, 1, 32'hFFFF_FFFF, 32'h0, 4'd1);
        step("rst1", 1, 1, 32'hFFFF_FFFF, 32'h0, 4'd1);
        chk("rst.gnt_zero", bus.gnt, 32'h0);
        chk("rst.busy_zero", 32'(bus.busy), 32'h0);
        step("first", 0, 1, 32'hFFFF_FFFF, 32'h0, 4'd1);
        chk("first.lane0", bus.gnt, 32'h1);

        // A single requester is re-granted with no idle cycle, then released.
        step("sr_rst", 1, 1, 32'h0, 32'h0, 4'd3);
        step("sr0", 0, 1, 32'h20, 32'h20, 4'd3);
        chk("sr.gnt", bus.gnt, 32'h20);
        chk("sr.sel", 32'(bus.sel), 32'd5);
        chk("sr.y", 32'(bus.y), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step("sr_hold", 0, 1, 32'h20, 32'h20, 4'd3);
            chk("sr.cont", 32'(bus.busy), 32'd1);
        end
        step("sr_drop", 0, 1, 32'h0, 32'h20, 4'd3);
        chk("sr.idle", bus.gnt, 32'h0);

        // Wrap from lane 31 back to lane 0.
        step("wr_rst", 1, 1, 32'h0, 32'h0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            step("wrap", 0, 1, 32'h8000_0011, 32'h8000_0010, 4'd1);
            chk("wrap.seq", 32'(bus.sel), 32'(seq[i]));
        end

        // Lane 7 releases early, so lane 9 takes over at the next edge.
        step("er_rst", 1, 1, 32'h0, 32'h0, 4'd8);
        step("er0", 0, 1, 32'h280, 32'hFFFF_FFFF, 4'd8);
        chk("er.lane7", 32'(bus.sel), 32'd7);
        step("er1", 0, 1, 32'h280, 32'hFFFF_FFFF, 4'd8);
        step("er_drop", 0, 1, 32'h200, 32'hFFFF_FFFF, 4'd8);
        chk("er.gnt9", bus.gnt, 32'h200);

        // hold_len of 0 behaves as 1; lowering en lets the running grant finish.
        step("h0_rst", 1, 1, 32'h0, 32'h0, 4'd0);
        for (int i = 0; i < 3; i++) step("h0", 0, 1, 32'h4, 32'h4, 4'd0);
        step("en_rst", 1, 1, 32'h0, 32'h0, 4'd4);
        step("en0", 0, 1, 32'h4, 32'h0, 4'd4);
        step("en1", 0, 1, 32'h4, 32'h0, 4'd4);
        step("en_low", 0, 0, 32'h4, 32'h0, 4'd4);
        step("en_low", 0, 0, 32'h4, 32'h0, 4'd4);
        chk("en.still_busy", 32'(bus.busy), 32'd1);
        step("en_end", 0, 0, 32'h4, 32'h0, 4'd4);
        chk("en.idle", 32'(bus.busy), 32'd0);
        step("en_stay", 0, 0, 32'h4, 32'h0, 4'd4);
        chk("en.no_new", bus.gnt, 32'h0);

        // Reset in the middle of a grant clears the pointer, so lane 3 wins next.
        step("rm_rst", 1, 1, 32'h0, 32'h0, 4'd10);
        for (int i = 0; i < 3; i++) step("rm", 0, 1, 32'h0010_0000, 32'h0, 4'd10);
        step("rm_pulse", 1, 1, 32'h0010_0000, 32'h0, 4'd10);
        chk("rm.gnt_zero", bus.gnt, 32'h0);
        step("rm_after", 0, 1, 32'h0200_0008, 32'h0, 4'd10);
        chk("rm.lane3", 32'(bus.sel), 32'd3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rq = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) rq = 32'd1 << $urandom_range(0, 31);
            step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, rq,
                 $urandom, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
